seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for a bank of seven-segment digits. The digit
// selects are scanned from digit 0 (rightmost) upwards. Each digit is lit for
// REFRESH_DIV cycles, followed by BLANK_CYCLES cycles with everything off to
// hide ghosting. The digit values, decimal points and the leading-zero flag
// are sampled once per frame, so a frame never mixes old and new values.
//
// Parameters
//   NUM_DIGITS   : number of multiplexed digits (2..8)
//   REFRESH_DIV  : clk cycles each digit is lit (>= 2)
//   BLANK_CYCLES : all-off cycles between digits (0 = no gap)
//   ACTIVE_LOW   : 1 = an/seg/dp driven active-low (common anode)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   enable     : scanning runs while high; low forces idle with outputs off
//   digits     : digit i value at [4i+3:4i], digit 0 rightmost
//   dp_in      : decimal-point request per digit
//   blank_zero : suppress leading zeros (digit 0 always shown)
//   an         : registered one-hot digit select
//   seg        : registered segment pattern {g,f,e,d,c,b,a}
//   dp         : registered decimal-point segment
//   frame_tick : registered one-cycle pulse (always active-high) that
//                coincides with the first lit cycle of digit 0 of a frame
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_zero,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  // The cycle counter is shared between SHOW and GAP, so it is sized for
  // whichever dwell is longer.
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  // Never used when BLANK_CYCLES is 0 (GAP is unreachable), kept legal anyway.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Inactive levels of the display outputs for the chosen polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State, counters and the per-frame snapshot
  // -------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic                    snap_blank_q;
  logic                    load_snap;
  logic                    advance;

  // Registered outputs and their next values.
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  // -------------------------------------------------------------------------
  // Segment decoder, active-high, bit order {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // -------------------------------------------------------------------------
  // Process 1: state register (also holds counter, index and snapshot)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      // The snapshot only moves at a frame boundary, so the digits shown in
      // one frame always come from the same sample of the inputs.
      if (load_snap) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp_in;
        snap_blank_q  <= blank_zero;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    load_snap = 1'b0;
    advance   = 1'b0;

    if (!enable) begin
      // Dropping enable parks the scanner from any state.
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SHOW;
          cnt_d     = '0;
          idx_d     = '0;
          load_snap = 1'b1;
        end

        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) begin
              advance = 1'b1;       // stay in SHOW, move to the next digit
            end else begin
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase

      // Stepping past the last digit starts a new frame and resamples inputs.
      if (advance) begin
        if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          load_snap = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero detection on the snapshot. upper_zero[i] is set when digits
  // i..NUM_DIGITS-1 are all zero. Built as a descending loop rather than a
  // self-referencing vector so the chain stays a plain combinational cone.
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] suppress;

  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (snap_digits_q[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  // Digit 0 is never suppressed so an all-zero value still shows "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_suppress
    if (gi == 0) begin : g_units
      assign suppress[gi] = 1'b0;
    end else begin : g_upper
      assign suppress[gi] = snap_blank_q && upper_zero[gi];
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  logic                  show_on;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [3:0]            cur_digit;
  logic                  cur_suppress;
  logic                  cur_dp;

  // Gating with enable turns the display off on the same edge that parks the
  // FSM, instead of showing one more stale lit cycle.
  assign show_on = enable && (state_q == SHOW);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_hi[gi] = show_on && (idx_q == IDX_W'(gi));
  end

  assign cur_digit    = snap_digits_q[{idx_q, 2'b00} +: 4];
  assign cur_suppress = suppress[idx_q];
  assign cur_dp       = snap_dp_q[idx_q];

  always_comb begin
    an_d   = an_hi ^ AN_OFF;
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    // idx 0 with cnt 0 occurs exactly once per frame, so this marks the first
    // lit cycle of every frame, lined up with the registered digit outputs.
    tick_d = show_on && (idx_q == '0) && (cnt_q == '0);
    if (show_on) begin
      seg_d = (cur_suppress ? 7'h00 : seg_decode(cur_digit)) ^ SEG_OFF;
      dp_d  = cur_dp ^ DP_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Three instances share clk/rst/enable:
//   dut_a : 4 digits, 4 lit cycles, 2 gap cycles, active-high (main target)
//   dut_b : same timing, active-low, digits 0x000F, dp_in 0010
//   dut_c : 4 digits, 3 lit cycles, no gap, active-high, digits 0x1234
// Sequence: reset state, cycle-exact scan of all three, a table of frames on
// dut_a checked through an expected-digit queue, then reset and enable
// interruptions with restart checks.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b0;
  logic        enable   = 1'b0;
  logic [15:0] digits_a = 16'h1234;
  logic [3:0]  dp_a     = 4'h0;
  logic        bz_a     = 1'b0;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_oa, dp_ob, dp_oc;
  logic       ft_a, ft_b, ft_c;

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .digits(digits_a), .dp_in(dp_a),
    .blank_zero(bz_a), .an(an_a), .seg(seg_a), .dp(dp_oa), .frame_tick(ft_a)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .digits(16'h000F), .dp_in(4'b0010),
    .blank_zero(1'b0), .an(an_b), .seg(seg_b), .dp(dp_ob), .frame_tick(ft_b)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(3), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .digits(16'h1234), .dp_in(4'b0000),
    .blank_zero(1'b0), .an(an_c), .seg(seg_c), .dp(dp_oc), .frame_tick(ft_c)
  );

  // Frame records: inputs plus the expected pattern of each digit
  // (seg packed {d3,d2,d1,d0}, 7 bits each, active-high).
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        bz;
    logic [27:0] seg;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  vec_t tbl [9];
  obs_t sbq [$];

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] prev_an  = 4'b0000;
  bit         sb_on    = 1'b0;
  bit         sb_live  = 1'b0;

  logic [6:0] seg_1234 [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: advance to the falling edge, then run the queue monitor.
  task automatic cycle();
    obs_t e;
    @(negedge clk);
    if (sb_on) begin
      if (ft_a && sbq.size() > 0) sb_live = 1'b1;
      if (sb_live && an_a != 4'b0000 && an_a != prev_an) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_digit actual_an=%b required=none", an_a);
        end else begin
          e = sbq.pop_front();
          check($sformatf("sb_digit an=%b", e.an),
                {20'd0, an_a, seg_a, dp_oa}, {20'd0, e.an, e.seg, e.dp});
        end
      end
    end
    prev_an = an_a;
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (an_a !== target && n < 60) begin
      cycle();
      n++;
    end
    check(name, {28'd0, an_a}, {28'd0, target});
  endtask

  task automatic wait_ft(input string name);
    int n;
    n = 0;
    while (ft_a !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    check(name, {31'd0, ft_a}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[1] = '{16'h5678, 4'b0000, 1'b0, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    tbl[2] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    tbl[3] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[4] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    tbl[5] = '{16'h9ABC, 4'b1010, 1'b0, {7'h6F, 7'h77, 7'h7C, 7'h39}};
    tbl[6] = '{16'hDEF0, 4'b0101, 1'b1, {7'h5E, 7'h79, 7'h71, 7'h3F}};
    tbl[7] = '{16'h0102, 4'b1000, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h5B}};
    tbl[8] = '{16'h0003, 4'b0100, 1'b1, {7'h00, 7'h00, 7'h00, 7'h4F}};

    // ---- reset state ----
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_a", {19'd0, an_a, seg_a, dp_oa, ft_a}, 32'd0);
    check("reset_b", {19'd0, an_b, seg_b, dp_ob, ft_b}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;
    cycle();
    check("idle_disabled_a", {19'd0, an_a, seg_a, dp_oa, ft_a}, 32'd0);

    // ---- cycle-exact scan of all three instances ----
    enable = 1'b1;
    cycle();
    check("first_edge_still_off", {28'd0, an_a}, 32'd0);
    for (int c = 0; c < 48; c++) begin
      int dg, dgc;
      logic lit, ft_e;
      logic [3:0] an_e, an_ce;
      logic [6:0] seg_e, seg_be;
      logic dp_be;
      cycle();
      dg    = (c / 6) % 4;
      lit   = (c % 6) < 4;
      ft_e  = (c % 24) == 0;
      an_e  = lit ? (4'b0001 << dg) : 4'b0000;
      seg_e = lit ? seg_1234[dg] : 7'h00;
      check($sformatf("scan_a c=%0d", c), {19'd0, an_a, seg_a, dp_oa, ft_a},
            {19'd0, an_e, seg_e, 1'b0, ft_e});
      seg_be = lit ? ~((dg == 0) ? 7'h71 : 7'h3F) : 7'h7F;
      dp_be  = lit ? (dg != 1) : 1'b1;
      check($sformatf("scan_b c=%0d", c), {19'd0, an_b, seg_b, dp_ob, ft_b},
            {19'd0, ~an_e, seg_be, dp_be, ft_e});
      dgc   = (c / 3) % 4;
      an_ce = 4'b0001 << dgc;
      check($sformatf("scan_c c=%0d", c), {19'd0, an_c, seg_c, dp_oc, ft_c},
            {19'd0, an_ce, seg_1234[dgc], 1'b0, (c % 12) == 0});
    end

    // ---- table of frames, inputs changed mid-frame ----
    sb_on   = 1'b1;
    sb_live = 1'b0;
    for (int r = 0; r < 9; r++) begin
      obs_t o;
      wait_ft($sformatf("frame_tick_before_rec%0d", r));
      repeat (8) cycle();
      digits_a = tbl[r].digits;
      dp_a     = tbl[r].dp;
      bz_a     = tbl[r].bz;
      for (int i = 0; i < 4; i++) begin
        o.an  = 4'b0001 << i;
        o.seg = tbl[r].seg[7*i +: 7];
        o.dp  = tbl[r].dp[i];
        sbq.push_back(o);
      end
      $display("tb: rec %0d digits=%h dp_in=%b blank_zero=%b queued", r,
               tbl[r].digits, tbl[r].dp, tbl[r].bz);
    end
    for (int n = 0; n < 80 && sbq.size() > 0; n++) cycle();
    check("sb_drain_left", sbq.size(), 32'd0);
    sb_on = 1'b0;

    // ---- reset pulse while digit 2 is lit ----
    wait_an(4'b0100, "wait_digit2");
    rst = 1'b1;
    #1;
    check("async_rst_a", {19'd0, an_a, seg_a, dp_oa, ft_a}, 32'd0);
    check("async_rst_b", {19'd0, an_b, seg_b, dp_ob, ft_b}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_release_off", {28'd0, an_a}, 32'd0);
    cycle();
    check("rst_restart_d0", {20'd0, an_a, seg_a, ft_a}, {20'd0, 4'b0001, 7'h4F, 1'b1});

    // ---- enable dropped during a gap ----
    wait_an(4'b0010, "wait_digit1");
    wait_an(4'b0000, "wait_gap");
    enable = 1'b0;
    cycle();
    check("en_drop_a", {19'd0, an_a, seg_a, dp_oa, ft_a}, 32'd0);
    check("en_drop_b", {19'd0, an_b, seg_b, dp_ob, ft_b}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    repeat (3) cycle();
    check("en_idle_hold", {19'd0, an_a, seg_a, dp_oa, ft_a}, 32'd0);
    check("en_idle_hold_c", {28'd0, an_c}, 32'd0);
    enable = 1'b1;
    cycle();
    check("reen_first_edge_off", {28'd0, an_a}, 32'd0);
    cycle();
    check("reen_restart_a", {20'd0, an_a, seg_a, ft_a}, {20'd0, 4'b0001, 7'h4F, 1'b1});
    check("reen_restart_c", {27'd0, an_c, ft_c}, {27'd0, 4'b0001, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
